// File: rtl/mac4_sequencer.sv
// Sequential 4-term unsigned dot product: accept a bundle, MAC one term per cycle, hand off result.
// Optional build macro MAC4_SATURATE_EN: saturating out_data plus a sat_flag output port.
module mac4_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     b0,
  input  logic [DATA_W-1:0]     b1,
  input  logic [DATA_W-1:0]     b2,
  input  logic [DATA_W-1:0]     b3,
  input  logic [4*DATA_W-1:0]   w_packed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [ACC_W-1:0]      acc_full,
  output logic [1:0]            sel,
`ifdef MAC4_SATURATE_EN
  output logic                  sat_flag,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [1:0]            sel_q, sel_d;
  logic [4*DATA_W-1:0]   ops_q, ops_d;
  logic [4*DATA_W-1:0]   wts_q, wts_d;
  logic [DATA_W-1:0]     op_s, wt_s;
  logic [2*DATA_W-1:0]   prod_s;
  logic                  over_s;

  // Operand/weight pair selected by the mux index and its product
  always_comb begin
    op_s   = ops_q[sel_q*DATA_W +: DATA_W];
    wt_s   = wts_q[sel_q*DATA_W +: DATA_W];
    prod_s = op_s * wt_s;
  end

  // Next-state logic for the sequencer and its datapath registers
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    ops_d   = ops_q;
    wts_d   = wts_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ops_d   = {b3, b2, b1, b0};
          wts_d   = w_packed;
          acc_d   = '0;
          sel_d   = 2'd0;
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_s);
        sel_d = sel_q + 2'd1;
        if (sel_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = MAC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        sel_d   = 2'd0;
      end
    endcase
  end

  // State and datapath registers; synchronous reset wins over any handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sel_q   <= 2'd0;
      ops_q   <= '0;
      wts_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      ops_q   <= ops_d;
      wts_q   <= wts_d;
    end
  end

  // Handshake and debug outputs decode directly from registered state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == MAC) || (state_q == DONE);
    sel       = sel_q;
    acc_full  = acc_q;
    over_s    = |acc_q[ACC_W-1:OUT_W];
  end

`ifdef MAC4_SATURATE_EN
  // Clamp to all-ones when the sum exceeds the output range
  always_comb begin
    out_data = over_s ? {OUT_W{1'b1}} : acc_q[OUT_W-1:0];
    sat_flag = over_s & out_valid;
  end
`else
  // Wrap-around truncation; the overflow indication is unused in this build
  always_comb begin
    out_data = acc_q[OUT_W-1:0] | {OUT_W{over_s & 1'b0}};
  end
`endif

endmodule

// File: tb/tb_mac4_sequencer.sv
// Self-checking bench for mac4_sequencer: table vectors, corner sequences, randomized bundles vs a dot-product model.
module tb_mac4_sequencer;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  b0, b1, b2, b3, out_data;
  logic [31:0] w_packed;
  logic [17:0] acc_full;
  logic [1:0]  sel;
`ifdef MAC4_SATURATE_EN
  logic        sat_flag;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac4_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .w_packed(w_packed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .acc_full(acc_full), .sel(sel),
`ifdef MAC4_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  typedef struct {
    logic [31:0] b;
    logic [31:0] w;
    int unsigned exp_acc;
    int unsigned exp_out;
    int          bp;
    string       nm;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain sum of four products, then the output reduction rule
  function automatic int unsigned model_acc(input logic [31:0] b, input logic [31:0] w);
    int unsigned s = 0;
    for (int i = 0; i < 4; i++) begin
      int unsigned x = b[i*8 +: 8];
      int unsigned y = w[i*8 +: 8];
      s += x * y;
    end
    return s;
  endfunction

  function automatic int unsigned model_out(input int unsigned acc);
`ifdef MAC4_SATURATE_EN
    return (acc > 255) ? 255 : acc;
`else
    return acc % 256;
`endif
  endfunction

  task automatic run_bundle(input logic [31:0] b, input logic [31:0] w, input int unsigned exp_acc,
                            input int unsigned exp_out, input int bp, input string nm);
    {b3, b2, b1, b0} = b;
    w_packed  = w;
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    chk({nm, " in_ready idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, " in_ready after accept"}, in_ready, 0);
    chk({nm, " busy"}, busy, 1);
    chk({nm, " sel0"}, sel, 0);
    {b3, b2, b1, b0} = ~b;
    w_packed = ~w;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk({nm, " sel step"}, sel, k);
      chk({nm, " no early valid"}, out_valid, 0);
    end
    @(posedge clk); #1;
    chk({nm, " out_valid"}, out_valid, 1);
    chk({nm, " acc_full"}, acc_full, exp_acc);
    chk({nm, " out_data"}, out_data, exp_out);
    chk({nm, " sel wrapped"}, sel, 0);
`ifdef MAC4_SATURATE_EN
    chk({nm, " sat_flag"}, sat_flag, (exp_acc > 255) ? 1 : 0);
`endif
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      chk({nm, " bp hold valid"}, out_valid, 1);
      chk({nm, " bp hold data"}, out_data, exp_out);
      chk({nm, " bp hold acc"}, acc_full, exp_acc);
      chk({nm, " bp in_ready"}, in_ready, 0);
      in_valid = (k == 0 && bp > 1);
      if (k == bp - 1) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, " valid drop"}, out_valid, 0);
    chk({nm, " back to idle"}, in_ready, 1);
    chk({nm, " acc frozen"}, acc_full, exp_acc);
  endtask

  initial begin
    int seen;
    logic [31:0] rb, rw;
    int unsigned ra;

    tbl[0] = '{32'h04030201, 32'h01010101, 10, 10, 0, "basic"};
    tbl[1] = '{32'h281E140A, 32'h01020304, 200, 200, 0, "weighted"};
`ifdef MAC4_SATURATE_EN
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 260100, 255, 0, "fullscale"};
`else
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 260100, 4, 0, "fullscale"};
`endif
    tbl[3] = '{32'h04030201, 32'h01010101, 10, 10, 7, "backpressure"};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    {b3, b2, b1, b0} = 32'h0; w_packed = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset acc_full", acc_full, 0);
    chk("reset sel", sel, 0);

    for (int i = 0; i < 4; i++)
      run_bundle(tbl[i].b, tbl[i].w, tbl[i].exp_acc, tbl[i].exp_out, tbl[i].bp, tbl[i].nm);

    // Reset together with a handshake: reset wins
    {b3, b2, b1, b0} = 32'h01010101; w_packed = 32'h01010101;
    in_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    chk("simul reset busy", busy, 0);
    chk("simul reset in_ready", in_ready, 1);
    reset = 1'b0; in_valid = 1'b0;

    // Reset on the second MAC edge discards the bundle
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midreset sel before", sel, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset in_ready", in_ready, 1);
    chk("midreset acc_full", acc_full, 0);
    chk("midreset sel", sel, 0);
    chk("midreset busy", busy, 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midreset no out_valid", seen, 0);

    // Back-to-back with in_valid held high
    {b3, b2, b1, b0} = 32'h01010101; w_packed = 32'h02020202;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b first accept", busy, 1);
    {b3, b2, b1, b0} = 32'h00000005; w_packed = 32'h00000003;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b first valid", out_valid, 1);
    chk("b2b first acc", acc_full, 8);
    chk("b2b first data", out_data, 8);
    @(posedge clk); #1;
    chk("b2b idle gap in_ready", in_ready, 1);
    chk("b2b idle gap busy", busy, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b second accept", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b second valid", out_valid, 1);
    chk("b2b second acc", acc_full, 15);
    chk("b2b second data", out_data, 15);
    @(posedge clk); #1;
    chk("b2b done", in_ready, 1);

    // Randomized bundles against the dot-product model
    for (int i = 0; i < 24; i++) begin
      rb = $urandom;
      rw = $urandom;
      if (i % 4 == 0) rb = rb | 32'hF0F0F0F0;
      ra = model_acc(rb, rw);
      run_bundle(rb, rw, ra, model_out(ra), $urandom_range(0, 3), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
